// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: datapath width, unit selects,
// opcodes and compare result codes.
package alu_pkg;

    localparam int WIDTH = 16;

    // Unit select, ALU_FUN[3:2]
    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] CMP   = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_GT   = 4'b1010;
    localparam logic [3:0] OP_LT   = 4'b1011;
    localparam logic [3:0] OP_SHRA = 4'b1100;
    localparam logic [3:0] OP_SHLA = 4'b1101;
    localparam logic [3:0] OP_SHRB = 4'b1110;
    localparam logic [3:0] OP_SHLB = 4'b1111;

    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;
    localparam logic [1:0] CMP_LT = 2'd3;

endpackage

// File: rtl/alu_decoder.sv
// Unit-select decoder: turns ALU_FUN[3:2] into one-hot unit enables that
// gate both the unit result registers and the flag register.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] unit_sel,
    output logic [3:0] unit_en
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        unit_en = '0;
        case (unit_sel)
            ARITH: unit_en[0] = 1'b1;
            LOGIC: unit_en[1] = 1'b1;
            CMP:   unit_en[2] = 1'b1;
            SHIFT: unit_en[3] = 1'b1;
            default: unit_en = '0;
        endcase
    end

endmodule

// File: rtl/alu_top.sv
// 16-bit registered ALU: four units each with their own result register;
// only the selected unit loads a result, the others are cleared.
module alu_top
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] Arith_Out,
    output logic             Carry_Out,
    output logic [WIDTH-1:0] Logic_Out,
    output logic [WIDTH-1:0] CMP_Out,
    output logic [WIDTH-1:0] SHIFT_Out,
    output logic [3:0]       flags_reg
);

    logic [3:0]       unit_en;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] arith_nxt;
    logic             carry_nxt;
    logic [WIDTH-1:0] logic_nxt;
    logic [WIDTH-1:0] cmp_nxt;
    logic [WIDTH-1:0] shift_nxt;

    alu_decoder u_decoder (
        .unit_sel (ALU_FUN[3:2]),
        .unit_en  (unit_en)
    );

    // Bit WIDTH of the extended difference is the borrow (set when A < B).
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    always_comb begin
        arith_nxt = '0;
        carry_nxt = 1'b0;
        case (ALU_FUN)
            OP_ADD: {carry_nxt, arith_nxt} = sum;
            OP_SUB: {carry_nxt, arith_nxt} = diff;
            OP_MUL: begin
                arith_nxt = prod[WIDTH-1:0];
                carry_nxt = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (B == '0) carry_nxt = 1'b1;
                else         arith_nxt = A / B;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic_nxt = '0;
        case (ALU_FUN)
            OP_AND:  logic_nxt = A & B;
            OP_OR:   logic_nxt = A | B;
            OP_NAND: logic_nxt = ~(A & B);
            OP_NOR:  logic_nxt = ~(A | B);
            default: ;
        endcase
    end

    always_comb begin
        cmp_nxt = '0;
        case (ALU_FUN)
            OP_NOP: cmp_nxt = '0;
            OP_EQ:  if (A == B) cmp_nxt = {{(WIDTH-2){1'b0}}, CMP_EQ};
            OP_GT:  if (A > B)  cmp_nxt = {{(WIDTH-2){1'b0}}, CMP_GT};
            OP_LT:  if (A < B)  cmp_nxt = {{(WIDTH-2){1'b0}}, CMP_LT};
            default: ;
        endcase
    end

    always_comb begin
        shift_nxt = '0;
        case (ALU_FUN)
            OP_SHRA: shift_nxt = A >> 1;
            OP_SHLA: shift_nxt = A << 1;
            OP_SHRB: shift_nxt = B >> 1;
            OP_SHLB: shift_nxt = B << 1;
            default: ;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every
    // unit samples the same pre-edge values regardless of block order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Arith_Out <= '0;
            Carry_Out <= 1'b0;
        end else if (unit_en[0]) begin
            Arith_Out <= arith_nxt;
            Carry_Out <= carry_nxt;
        end else begin
            Arith_Out <= '0;
            Carry_Out <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)            Logic_Out <= '0;
        else if (unit_en[1]) Logic_Out <= logic_nxt;
        else                 Logic_Out <= '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)            CMP_Out <= '0;
        else if (unit_en[2]) CMP_Out <= cmp_nxt;
        else                 CMP_Out <= '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)            SHIFT_Out <= '0;
        else if (unit_en[3]) SHIFT_Out <= shift_nxt;
        else                 SHIFT_Out <= '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) flags_reg <= '0;
        else      flags_reg <= unit_en;
    end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed and random operations compared
// against an arithmetic reference model, plus asynchronous reset checks.
module tb_alu_top;

    logic        CLK;
    logic        RST;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUN;
    logic [15:0] Arith_Out;
    logic        Carry_Out;
    logic [15:0] Logic_Out;
    logic [15:0] CMP_Out;
    logic [15:0] SHIFT_Out;
    logic [3:0]  flags_reg;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [15:0] arith;
        logic        carry;
        logic [15:0] logic_r;
        logic [15:0] cmp;
        logic [15:0] shift;
        logic [3:0]  flags;
    } res_t;

    alu_top dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .Arith_Out (Arith_Out),
        .Carry_Out (Carry_Out),
        .Logic_Out (Logic_Out),
        .CMP_Out   (CMP_Out),
        .SHIFT_Out (SHIFT_Out),
        .flags_reg (flags_reg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: results computed with plain integer arithmetic.
    function automatic res_t model(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        int unsigned ua;
        int unsigned ub;
        int unsigned t;
        r  = '0;
        ua = a;
        ub = b;
        t  = 0;
        case (fun)
            4'd0: begin t = ua + ub; r.arith = t[15:0]; r.carry = (t > 65535); end
            4'd1: begin t = ua - ub; r.arith = t[15:0]; r.carry = (ua < ub); end
            4'd2: begin t = ua * ub; r.arith = t[15:0]; r.carry = (t > 65535); end
            4'd3: begin
                if (ub == 0) begin r.arith = 16'd0; r.carry = 1'b1; end
                else begin t = ua / ub; r.arith = t[15:0]; end
            end
            4'd4:  r.logic_r = a & b;
            4'd5:  r.logic_r = a | b;
            4'd6:  r.logic_r = ~(a & b);
            4'd7:  r.logic_r = ~(a | b);
            4'd8:  r.cmp = 16'd0;
            4'd9:  r.cmp = (ua == ub) ? 16'd1 : 16'd0;
            4'd10: r.cmp = (ua > ub)  ? 16'd2 : 16'd0;
            4'd11: r.cmp = (ua < ub)  ? 16'd3 : 16'd0;
            4'd12: begin t = ua / 2; r.shift = t[15:0]; end
            4'd13: begin t = ua * 2; r.shift = t[15:0]; end
            4'd14: begin t = ub / 2; r.shift = t[15:0]; end
            default: begin t = ub * 2; r.shift = t[15:0]; end
        endcase
        r.flags = 4'b0001 << fun[3:2];
        return r;
    endfunction

    function automatic res_t observe();
        return {Arith_Out, Carry_Out, Logic_Out, CMP_Out, SHIFT_Out, flags_reg};
    endfunction

    function automatic string show(input res_t r);
        return $sformatf("arith=%h carry=%b logic=%h cmp=%h shift=%h flags=%b",
                         r.arith, r.carry, r.logic_r, r.cmp, r.shift, r.flags);
    endfunction

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'(1 << $urandom_range(0, 15));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // Applies inputs at the falling edge and returns 1 ns after the next rising edge.
    task automatic drive_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        ALU_FUN = f;
        A       = a;
        B       = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        res_t exp, obs;
        RST = 1'b0; A = 16'd1234; B = 16'd77; ALU_FUN = 4'b0010;
        repeat (2) @(posedge CLK);
        #1;
        obs = observe();
        exp = '0;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_hold: got %s, expected %s", show(obs), show(exp));
        end
        @(negedge CLK);
        RST = 1'b1;
        drive_op(4'b0000, 16'd15, 16'd15);
        obs = observe();
        exp = '0; exp.arith = 16'd30; exp.flags = 4'b0001;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_first_op: got %s, expected %s", show(obs), show(exp));
        end
    endtask

    // Directed vectors for one unit, then random operations within the same unit.
    task automatic test_unit(input string name, input logic [1:0] unit, input logic [35:0] vecs [6]);
        res_t exp, obs;
        logic [3:0]  f;
        logic [15:0] a, b;
        for (int i = 0; i < 6; i++) begin
            {f, a, b} = vecs[i];
            drive_op(f, a, b);
            obs = observe();
            exp = model(f, a, b);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL %s_dir%0d fun=%b a=%h b=%h: got %s, expected %s",
                         name, i, f, a, b, show(obs), show(exp));
            end
        end
        for (int i = 0; i < 25; i++) begin
            f = {unit, 2'($urandom_range(0, 3))};
            a = rand_operand();
            b = (i % 5 == 0) ? a : rand_operand();
            drive_op(f, a, b);
            obs = observe();
            exp = model(f, a, b);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL %s_rand%0d fun=%b a=%h b=%h: got %s, expected %s",
                         name, i, f, a, b, show(obs), show(exp));
            end
        end
    endtask

    task automatic test_arith();
        logic [35:0] v [6];
        v = '{{4'b0001, 16'd65,    16'd15},
              {4'b0010, 16'd8,     16'd9},
              {4'b0011, 16'd80,    16'd10},
              {4'b0000, 16'hFFFF,  16'd1},
              {4'b0011, 16'd1234,  16'd0},
              {4'b0010, 16'h0100,  16'h0100}};
        test_unit("arith", 2'b00, v);
    endtask

    task automatic test_logic();
        logic [35:0] v [6];
        v = '{{4'b0100, 16'd15,    16'd8},
              {4'b0101, 16'd7,     16'd8},
              {4'b0110, 16'hFFFF,  16'hFFFC},
              {4'b0111, 16'hFFFE,  16'd2},
              {4'b0100, 16'hA5A5,  16'h0FF0},
              {4'b0111, 16'h0000,  16'h0000}};
        test_unit("logic", 2'b01, v);
    endtask

    task automatic test_cmp();
        logic [35:0] v [6];
        v = '{{4'b1000, 16'd5,     16'd2},
              {4'b1001, 16'd5,     16'd5},
              {4'b1010, 16'd8,     16'd5},
              {4'b1011, 16'd2,     16'd5},
              {4'b1001, 16'd5,     16'd6},
              {4'b1010, 16'hFFFF,  16'h7FFF}};
        test_unit("cmp", 2'b10, v);
    endtask

    task automatic test_shift();
        logic [35:0] v [6];
        v = '{{4'b1100, 16'd8,     16'd0},
              {4'b1101, 16'd4,     16'd0},
              {4'b1110, 16'd0,     16'd7},
              {4'b1111, 16'd0,     16'd7},
              {4'b1101, 16'h8000,  16'd0},
              {4'b1100, 16'd1,     16'h8001}};
        test_unit("shift", 2'b11, v);
    endtask

    // Random opcode every cycle; outputs must hold the previous result until the edge.
    task automatic test_back_to_back();
        res_t exp, obs, prev;
        logic [3:0]  f;
        logic [15:0] a, b;
        prev = observe() === model(4'b1111, 16'd0, 16'd0) ? model(4'b1111, 16'd0, 16'd0) : 'x;
        for (int i = 0; i < 60; i++) begin
            f = 4'($urandom_range(0, 15));
            a = rand_operand();
            b = rand_operand();
            @(negedge CLK);
            ALU_FUN = f; A = a; B = b;
            #1;
            if (i > 0) begin
                obs = observe();
                tests_run++;
                if (obs !== prev) begin
                    tests_failed++;
                    $display("FAIL b2b_hold%0d: got %s, expected %s", i, show(obs), show(prev));
                end
            end
            @(posedge CLK);
            #1;
            obs = observe();
            exp = model(f, a, b);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL b2b%0d fun=%b a=%h b=%h: got %s, expected %s",
                         i, f, a, b, show(obs), show(exp));
            end
            prev = exp;
        end
    endtask

    // Reset asserted between edges must clear every output at once.
    task automatic test_async_reset();
        res_t exp, obs;
        for (int i = 0; i < 4; i++) begin
            drive_op(4'(i * 4 + 1), 16'd9, 16'd3);
            #2;
            RST = 1'b0;
            #1;
            obs = observe();
            exp = '0;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL async_reset%0d: got %s, expected %s", i, show(obs), show(exp));
            end
            @(posedge CLK);
            #1;
            obs = observe();
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_over_edge%0d: got %s, expected %s", i, show(obs), show(exp));
            end
            #2;
            RST = 1'b1;
            drive_op(4'b0000, 16'hFFFF, 16'd1);
            obs = observe();
            exp = model(4'b0000, 16'hFFFF, 16'd1);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL post_reset%0d: got %s, expected %s", i, show(obs), show(exp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_cmp();
        test_shift();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
